sensor_tick_scheduler: RTL and testbench

- Builds a 1 us tick enable from the 50 MHz system clock with a prescaler, replacing divided-clock outputs.
- Schedules periodic service slots for up to NCH sensor/actuator channels, each with a programmable period counted in ticks.
- When several channels are due at once, a round-robin arbiter grants the shared service path to one channel at a time.
- Each grant is held until the granted channel acknowledges it.

---
 rtl/sensor_tick_scheduler.sv | 160 ++++++++++++++++
 tb/tb_sensor_tick_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_tick_scheduler.sv
// Periodic service scheduler: 1 us tick prescaler, per-channel period countdowns,
// and a round-robin arbiter that holds a one-hot grant until the channel acks it.
module sensor_tick_scheduler #(
  parameter int CLK_DIV = 50,
  parameter int NCH     = 4,
  parameter int PW      = 16,
  parameter int CHW     = 2
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           enable,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic [NCH-1:0] ack,
  output logic           tick_us,
  output logic [NCH-1:0] grant,
  output logic           grant_valid,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] overrun,
  output logic           dbg_state
);

  localparam int PSW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // Handshake: grant is the valid and ack the ready of the service path; a grant
  // stays asserted until the matching ack bit is seen, other ack bits are ignored.
  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t         r_state;
  logic [PSW-1:0] r_presc;
  logic           r_tick;
  logic [PW-1:0]  r_period [NCH];
  logic [PW-1:0]  r_cnt    [NCH];
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_ovr;
  logic [NCH-1:0] r_grant;
  logic [CHW-1:0] r_gidx;
  logic [CHW-1:0] r_ptr;

  logic           w_tick;
  logic [NCH-1:0] w_wr;
  logic [NCH-1:0] w_due;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_pend_nxt;
  logic [NCH-1:0] w_ovr_nxt;
  logic           w_sel_found;
  logic [CHW-1:0] w_sel_idx;

  assign w_tick = r_tick & enable;

  always_comb begin
    w_wr       = '0;
    w_due      = '0;
    w_clr      = '0;
    w_pend_nxt = r_pend;
    w_ovr_nxt  = r_ovr;
    for (int i = 0; i < NCH; i++) begin
      w_wr[i]  = cfg_we && (cfg_ch == CHW'(i));
      w_clr[i] = (r_state == S_GRANT) && r_grant[i] && ack[i];
      w_due[i] = w_tick && (r_period[i] != '0) && !w_wr[i] && (r_cnt[i] == PW'(1));
      if (w_wr[i]) begin
        w_pend_nxt[i] = 1'b0;
        w_ovr_nxt[i]  = 1'b0;
      end else begin
        // A due that lands on the clearing ack re-arms pending without an overrun.
        if (w_due[i] && r_pend[i] && !w_clr[i]) w_ovr_nxt[i] = 1'b1;
        if (w_due[i]) w_pend_nxt[i] = 1'b1;
        else if (w_clr[i]) w_pend_nxt[i] = 1'b0;
      end
    end
  end

  // Arbitrate on next-cycle pending so a fresh due is granted the cycle after its tick.
  always_comb begin : p_sel
    int j;
    j           = 0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (!w_sel_found && w_pend_nxt[CHW'(j)]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = CHW'(j);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_pend  <= '0;
      r_ovr   <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_period[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      if (enable) begin
        if (r_presc == PSW'(CLK_DIV - 1)) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + PSW'(1);
          r_tick  <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
      r_pend <= w_pend_nxt;
      r_ovr  <= w_ovr_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (w_wr[i]) begin
          r_period[i] <= cfg_period;
          r_cnt[i]    <= cfg_period;
        end else if (w_tick && (r_period[i] != '0)) begin
          if (r_cnt[i] == PW'(1)) r_cnt[i] <= r_period[i];
          else r_cnt[i] <= r_cnt[i] - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && w_sel_found) begin
            r_grant <= NCH'(1) << w_sel_idx;
            r_gidx  <= w_sel_idx;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (|(r_grant & ack)) begin
            r_grant <= '0;
            r_ptr   <= (r_gidx == CHW'(NCH - 1)) ? '0 : r_gidx + CHW'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tick_us     = r_tick;
  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign pending     = r_pend;
  assign overrun     = r_ovr;
  assign dbg_state   = (r_state == S_GRANT);

endmodule

// File: tb/tb_sensor_tick_scheduler.sv
// Bench for sensor_tick_scheduler: directed scenarios plus random traffic, every
// cycle compared against a tick-number based reference model.
module tb_sensor_tick_scheduler;

  localparam int CLK_DIV = 50;
  localparam int NCH     = 4;
  localparam int PW      = 16;
  localparam int CHW     = 2;

  logic           clk_in = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic [NCH-1:0] ack = '0;
  logic           tick_us;
  logic [NCH-1:0] grant;
  logic           grant_valid;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] overrun;
  logic           dbg_state;

  always #10 clk_in = ~clk_in;

  sensor_tick_scheduler #(.CLK_DIV(CLK_DIV), .NCH(NCH), .PW(PW), .CHW(CHW)) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .ack(ack), .tick_us(tick_us), .grant(grant),
    .grant_valid(grant_valid), .pending(pending), .overrun(overrun), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: absolute tick numbers instead of countdowns.
  bit             m_tick;
  int             m_en_edges;
  int             m_tick_num;
  int             m_per [NCH];
  int             m_next_due [NCH];
  bit [NCH-1:0]   m_pend;
  bit [NCH-1:0]   m_ovr;
  int             m_grant;
  int             m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] exp_grant();
    logic [NCH-1:0] v;
    v = '0;
    if (m_grant >= 0) v[m_grant] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_tick = 0; m_en_edges = 0; m_tick_num = 0;
    m_pend = '0; m_ovr = '0; m_grant = -1; m_ptr = 0;
    for (int i = 0; i < NCH; i++) begin
      m_per[i] = 0;
      m_next_due[i] = 0;
    end
  endtask

  task automatic model_update();
    bit tick_eff, wr, due, clr, found;
    int j;
    if (rst) begin
      model_reset();
      return;
    end
    tick_eff = m_tick && enable;
    if (tick_eff) m_tick_num++;
    for (int i = 0; i < NCH; i++) begin
      wr  = cfg_we && (int'(cfg_ch) == i);
      due = tick_eff && (m_per[i] != 0) && !wr && (m_tick_num == m_next_due[i]);
      if (due) m_next_due[i] += m_per[i];
      clr = (m_grant == i) && ack[i];
      if (wr) begin
        m_per[i] = int'(cfg_period);
        m_next_due[i] = m_tick_num + int'(cfg_period);
        m_pend[i] = 0;
        m_ovr[i] = 0;
      end else begin
        if (due && m_pend[i] && !clr) m_ovr[i] = 1;
        if (due) m_pend[i] = 1;
        else if (clr) m_pend[i] = 0;
      end
    end
    if (m_grant < 0) begin
      found = 0;
      if (enable) begin
        for (int k = 0; k < NCH; k++) begin
          j = (m_ptr + k) % NCH;
          if (!found && m_pend[j]) begin
            found = 1;
            m_grant = j;
          end
        end
      end
    end else if (ack[m_grant]) begin
      m_ptr = (m_grant + 1) % NCH;
      m_grant = -1;
    end
    if (enable) begin
      m_en_edges++;
      m_tick = (m_en_edges % CLK_DIV) == 0;
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic compare();
    check("tick_us", 32'(tick_us), 32'(m_tick));
    check("grant", 32'(grant), 32'(exp_grant()));
    check("grant_valid", 32'(grant_valid), 32'(m_grant >= 0));
    check("pending", 32'(pending), 32'(m_pend));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("state", 32'(dbg_state), 32'(m_grant >= 0));
  endtask

  task automatic step();
    model_update();
    @(posedge clk_in);
    @(negedge clk_in);
    compare();
  endtask

  task automatic write_cfg(input int ch, input int per);
    cfg_we = 1'b1;
    cfg_ch = CHW'(ch);
    cfg_period = PW'(per);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_us && n < 300);
    check("tick_bound", 32'(tick_us), 32'd1);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!grant_valid && n < 1000);
    check("grant_bound", 32'(grant_valid), 32'd1);
  endtask

  initial begin
    int n, ticks, cnt;
    bit prev;
    model_reset();
    @(negedge clk_in);

    // Tick timebase and pause behaviour.
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tick", 32'(tick_us), 32'd0);
    enable = 1'b1;
    wait_tick(n);
    check("first_tick", n, 50);
    wait_tick(n);
    check("tick_period", n, 50);
    for (int i = 0; i < 20; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    enable = 1'b1;
    wait_tick(n);
    check("tick_after_pause", n, 30);

    // Single channel, period 3, ack two cycles after grant.
    step();
    write_cfg(1, 3);
    ticks = 0; prev = 0; n = 0;
    while (!grant_valid && n < 1000) begin
      prev = tick_us;
      step();
      n++;
      if (tick_us) ticks++;
    end
    check("single_grant", 32'(grant), 32'b0010);
    check("single_ticks", ticks, 3);
    check("single_after_tick", 32'(prev), 32'd1);
    n = 0;
    step(); n++;
    step(); n++;
    ack = grant; step(); n++; ack = '0;
    check("single_released", 32'(grant), 32'd0);
    check("single_pend_clr", 32'(pending), 32'd0);
    while (!grant_valid && n < 1000) begin
      step();
      n++;
    end
    check("single_repeat", n, 150);
    check("single_overrun", 32'(overrun), 32'd0);
    ack = grant; step(); ack = '0;

    // Round robin across all channels, two rounds.
    do_reset();
    for (int c = 0; c < NCH; c++) write_cfg(c, 2);
    for (int g = 0; g < 2 * NCH; g++) begin
      wait_grant(n);
      check("rr_order", 32'(grant), 32'(1 << (g % NCH)));
      ack = grant; step(); ack = '0;
    end

    // Overrun with withheld ack, rewrite clears flags, then reset mid-grant.
    do_reset();
    write_cfg(2, 1);
    wait_tick(n);
    step();
    check("ovr_grant", 32'(grant), 32'b0100);
    check("ovr_pend1", 32'(pending[2]), 32'd1);
    check("ovr_none_yet", 32'(overrun[2]), 32'd0);
    wait_tick(n);
    step();
    check("ovr_set", 32'(overrun[2]), 32'd1);
    check("ovr_pend2", 32'(pending[2]), 32'd1);
    for (int i = 0; i < 60; i++) step();
    write_cfg(2, 0);
    check("ovr_wr_clr", 32'(overrun[2]), 32'd0);
    check("ovr_wr_pend", 32'(pending[2]), 32'd0);
    check("ovr_grant_held", 32'(grant), 32'b0100);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_gvalid", 32'(grant_valid), 32'd0);
    check("midrst_pend", 32'(pending), 32'd0);
    wait_tick(n);
    check("midrst_first_tick", n, 50);

    // Disable while pending and write-over-tick priority.
    do_reset();
    write_cfg(0, 1);
    wait_tick(n);
    step();
    check("dis_pend", 32'(pending[0]), 32'd1);
    write_cfg(0, 0);
    check("dis_pend_clr", 32'(pending[0]), 32'd0);
    check("dis_grant_held", 32'(grant), 32'b0001);
    ack = 4'b0001; step(); ack = '0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (grant[0]) cnt++;
    end
    check("dis_no_grant", cnt, 0);
    write_cfg(3, 1);
    wait_tick(n);
    step();
    check("wp_grant", 32'(grant), 32'b1000);
    ack = grant; step(); ack = '0;
    wait_tick(n);
    write_cfg(3, 2);
    check("wp_no_due", 32'(pending[3]), 32'd0);
    wait_tick(n);
    step();
    check("wp_still_idle", 32'(pending[3]), 32'd0);
    wait_tick(n);
    step();
    check("wp_due", 32'(grant), 32'b1000);

    // Random traffic against the model.
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 15000; c++) begin
      rst = ($urandom_range(0, 4999) == 0);
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      cfg_we = ($urandom_range(0, 149) == 0);
      cfg_ch = CHW'($urandom_range(0, NCH - 1));
      cfg_period = PW'($urandom_range(0, 4));
      ack = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
      if (grant_valid && $urandom_range(0, 5) == 0) ack = ack | grant;
      step();
    end
    rst = 1'b0; cfg_we = 1'b0; ack = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
